// File: rtl/regfile_mp_csr.sv
// Multi-port GPR file with a CSR bank, atomic trap/mret update, busy scoreboard
// and a post-reset clear sequence that zeroes the GPRs before `ready` rises.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   ready                        clear sequence done, writes accepted
//   rd_addr/rd_data/rd_busy      NR combinational GPR read ports + busy bits
//   wr_en/wr_addr/wr_data        NW GPR write ports (highest index wins)
//   sb_set_en/sb_set_addr        mark a destination busy at issue
//   csr_raddr/csr_rdata          combinational CSR read
//   csr_wen/csr_waddr/csr_wdata  CSR write
//   trap_en/trap_epc/trap_cause  trap entry (mepc, mcause, mstatus)
//   mret_en                      trap return (mstatus)
//
// Build option: define REGFILE_BYPASS_EN for write-to-read forwarding.
module regfile_mp_csr #(
    parameter int DW = 64,
    parameter int AW = 5,
    parameter int NR = 2,
    parameter int NW = 2,
    parameter int NCSR = 4,
    parameter logic [DW-1:0] MSTATUS_RST = 64'ha00001800,
    localparam int CAW = $clog2(NCSR)
) (
    input  logic             clk,
    input  logic             rst,
    output logic             ready,
    input  logic [NR*AW-1:0] rd_addr,
    output logic [NR*DW-1:0] rd_data,
    output logic [NR-1:0]    rd_busy,
    input  logic [NW-1:0]    wr_en,
    input  logic [NW*AW-1:0] wr_addr,
    input  logic [NW*DW-1:0] wr_data,
    input  logic             sb_set_en,
    input  logic [AW-1:0]    sb_set_addr,
    input  logic [CAW-1:0]   csr_raddr,
    output logic [DW-1:0]    csr_rdata,
    input  logic             csr_wen,
    input  logic [CAW-1:0]   csr_waddr,
    input  logic [DW-1:0]    csr_wdata,
    input  logic             trap_en,
    input  logic [DW-1:0]    trap_epc,
    input  logic [DW-1:0]    trap_cause,
    input  logic             mret_en
);

    localparam int NREG = 2 ** AW;
    localparam int CSR_MSTATUS = 0;
    localparam int CSR_MEPC = 2;
    localparam int CSR_MCAUSE = 3;

    typedef enum logic {
        S_INIT,
        S_RUN
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   clr_idx_q, clr_idx_d;
    logic            ready_q, ready_d;
    logic [NREG-1:0] busy_q, busy_d;
    logic [DW-1:0]   rf_q [NREG];
    logic [DW-1:0]   rf_d [NREG];
    logic [DW-1:0]   csr_q [NCSR];
    logic [DW-1:0]   csr_d [NCSR];
    logic            run;

    assign run = (state_q == S_RUN);
    assign ready = ready_q;

    always_comb begin
        state_d = state_q;
        clr_idx_d = clr_idx_q;
        ready_d = ready_q;
        if (!run) begin
            clr_idx_d = clr_idx_q + 1'b1;
            if (clr_idx_q == '1) begin
                state_d = S_RUN;
                ready_d = 1'b1;
            end
        end
    end

    // GPR next state; ascending loop makes the highest write port win.
    always_comb begin
        rf_d = rf_q;
        if (!rst) begin
            if (!run) begin
                rf_d[clr_idx_q] = '0;
            end else begin
                for (int j = 0; j < NW; j++) begin
                    if (wr_en[j] && wr_addr[j*AW +: AW] != '0) begin
                        rf_d[wr_addr[j*AW +: AW]] = wr_data[j*DW +: DW];
                    end
                end
            end
        end
    end

    // Clears first so a same-cycle set on the same entry wins.
    always_comb begin
        busy_d = busy_q;
        if (run) begin
            for (int j = 0; j < NW; j++) begin
                if (wr_en[j]) begin
                    busy_d[wr_addr[j*AW +: AW]] = 1'b0;
                end
            end
            if (sb_set_en) begin
                busy_d[sb_set_addr] = 1'b1;
            end
        end
        busy_d[0] = 1'b0;
    end

    // Layered so trap overrides mret, which overrides the plain CSR write,
    // field by field; untouched fields keep the csr_wen value.
    always_comb begin
        csr_d = csr_q;
        if (run) begin
            if (csr_wen) begin
                csr_d[csr_waddr] = csr_wdata;
            end
            if (mret_en) begin
                csr_d[CSR_MSTATUS][3] = csr_q[CSR_MSTATUS][7];
                csr_d[CSR_MSTATUS][7] = 1'b1;
                csr_d[CSR_MSTATUS][12:11] = 2'b00;
            end
            if (trap_en) begin
                csr_d[CSR_MEPC] = trap_epc;
                csr_d[CSR_MCAUSE] = trap_cause;
                csr_d[CSR_MSTATUS][7] = csr_q[CSR_MSTATUS][3];
                csr_d[CSR_MSTATUS][3] = 1'b0;
                csr_d[CSR_MSTATUS][12:11] = 2'b11;
            end
        end
    end

    always_ff @(posedge clk) begin
        rf_q <= rf_d;
        if (rst) begin
            state_q <= S_INIT;
            clr_idx_q <= '0;
            ready_q <= 1'b0;
            busy_q <= '0;
            for (int i = 0; i < NCSR; i++) begin
                csr_q[i] <= '0;
            end
            csr_q[CSR_MSTATUS] <= MSTATUS_RST;
        end else begin
            state_q <= state_d;
            clr_idx_q <= clr_idx_d;
            ready_q <= ready_d;
            busy_q <= busy_d;
            csr_q <= csr_d;
        end
    end

    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int i = 0; i < NR; i++) begin
            if (run && rd_addr[i*AW +: AW] != '0) begin
                rd_data[i*DW +: DW] = rf_q[rd_addr[i*AW +: AW]];
                rd_busy[i] = busy_q[rd_addr[i*AW +: AW]];
`ifdef REGFILE_BYPASS_EN
                for (int j = 0; j < NW; j++) begin
                    if (wr_en[j] && wr_addr[j*AW +: AW] == rd_addr[i*AW +: AW]) begin
                        rd_data[i*DW +: DW] = wr_data[j*DW +: DW];
                        rd_busy[i] = 1'b0;
                    end
                end
`endif
            end
        end
    end

    always_comb begin
        csr_rdata = csr_q[csr_raddr];
`ifdef REGFILE_BYPASS_EN
        if (run && csr_wen && csr_waddr == csr_raddr) begin
            csr_rdata = csr_wdata;
        end
`endif
    end

endmodule

// File: tb/tb_regfile_mp_csr.sv
// Directed bench for regfile_mp_csr: a GPR/scoreboard vector table plus
// hand-written trap, mret, mid-clear reset and forwarding sequences.
module tb_regfile_mp_csr;

    logic         clk = 1'b0;
    logic         rst;
    logic         ready;
    logic [9:0]   rd_addr;
    logic [127:0] rd_data;
    logic [1:0]   rd_busy;
    logic [1:0]   wr_en;
    logic [9:0]   wr_addr;
    logic [127:0] wr_data;
    logic         sb_set_en;
    logic [4:0]   sb_set_addr;
    logic [1:0]   csr_raddr;
    logic [63:0]  csr_rdata;
    logic         csr_wen;
    logic [1:0]   csr_waddr;
    logic [63:0]  csr_wdata;
    logic         trap_en;
    logic [63:0]  trap_epc;
    logic [63:0]  trap_cause;
    logic         mret_en;

    int n_chk = 0;
    int n_pass = 0;

    regfile_mp_csr dut (
        .clk(clk), .rst(rst), .ready(ready),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .sb_set_en(sb_set_en), .sb_set_addr(sb_set_addr),
        .csr_raddr(csr_raddr), .csr_rdata(csr_rdata),
        .csr_wen(csr_wen), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
        .trap_en(trap_en), .trap_epc(trap_epc), .trap_cause(trap_cause),
        .mret_en(mret_en)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  we;
        logic [4:0]  wa0;
        logic [63:0] wd0;
        logic [4:0]  wa1;
        logic [63:0] wd1;
        logic        se;
        logic [4:0]  sa;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [63:0] e0;
        logic [63:0] e1;
        logic        b0;
        logic        b1;
    } vec_t;

    vec_t vt [7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en = 2'b00;
        sb_set_en = 1'b0;
        csr_wen = 1'b0;
        trap_en = 1'b0;
        mret_en = 1'b0;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!ready && n < 100) begin
            tick();
            n++;
        end
    endtask

    task automatic rd_gpr(input logic [4:0] a, output logic [63:0] d, output logic b);
        rd_addr = {5'd0, a};
        #1;
        d = rd_data[63:0];
        b = rd_busy[0];
    endtask

    task automatic rd_csr(input logic [1:0] a, output logic [63:0] d);
        csr_raddr = a;
        #1;
        d = csr_rdata;
    endtask

    logic [63:0] d;
    logic        b;
    int          n;
    logic        nz;

    initial begin
        vt[0] = '{2'b11, 5'd5, 64'h11, 5'd5, 64'h22, 1'b0, 5'd0,
                  5'd5, 5'd0, 64'h22, 64'h0, 1'b0, 1'b0};
        vt[1] = '{2'b11, 5'd0, 64'hff, 5'd6, 64'h66, 1'b0, 5'd0,
                  5'd0, 5'd6, 64'h0, 64'h66, 1'b0, 1'b0};
        vt[2] = '{2'b00, 5'd0, 64'h0, 5'd0, 64'h0, 1'b1, 5'd7,
                  5'd7, 5'd6, 64'h0, 64'h66, 1'b1, 1'b0};
        vt[3] = '{2'b01, 5'd7, 64'h77, 5'd0, 64'h0, 1'b1, 5'd7,
                  5'd7, 5'd5, 64'h77, 64'h22, 1'b1, 1'b0};
        vt[4] = '{2'b10, 5'd0, 64'h0, 5'd7, 64'h78, 1'b0, 5'd0,
                  5'd7, 5'd7, 64'h78, 64'h78, 1'b0, 1'b0};
        vt[5] = '{2'b11, 5'd8, 64'h88, 5'd9, 64'h99, 1'b1, 5'd10,
                  5'd8, 5'd10, 64'h88, 64'h0, 1'b0, 1'b1};
        vt[6] = '{2'b01, 5'd10, 64'haa, 5'd0, 64'h0, 1'b1, 5'd0,
                  5'd10, 5'd0, 64'haa, 64'h0, 1'b0, 1'b0};

        rst = 1'b1;
        idle();
        rd_addr = '0;
        wr_addr = '0;
        wr_data = '0;
        sb_set_addr = '0;
        csr_raddr = '0;
        csr_waddr = '0;
        csr_wdata = '0;
        trap_epc = '0;
        trap_cause = '0;

        tick();
        tick();
        chk("ready_in_reset", 64'(ready), 64'h0);
        rst = 1'b0;
        wait_ready(n);
        chk("ready_latency", 64'(n), 64'd32);

        nz = 1'b0;
        for (int i = 0; i < 32; i++) begin
            rd_gpr(5'(i), d, b);
            if (d != 64'h0 || b) nz = 1'b1;
        end
        chk("gpr_all_zero", 64'(nz), 64'h0);
        rd_csr(2'd0, d);
        chk("mstatus_rst", d, 64'ha00001800);
        rd_csr(2'd2, d);
        chk("mepc_rst", d, 64'h0);

        for (int k = 0; k < 7; k++) begin
            wr_en = vt[k].we;
            wr_addr = {vt[k].wa1, vt[k].wa0};
            wr_data = {vt[k].wd1, vt[k].wd0};
            sb_set_en = vt[k].se;
            sb_set_addr = vt[k].sa;
            tick();
            idle();
            rd_addr = {vt[k].ra1, vt[k].ra0};
            #1;
            chk($sformatf("v%0d_rd0", k), rd_data[63:0], vt[k].e0);
            chk($sformatf("v%0d_rd1", k), rd_data[127:64], vt[k].e1);
            chk($sformatf("v%0d_busy0", k), 64'(rd_busy[0]), 64'(vt[k].b0));
            chk($sformatf("v%0d_busy1", k), 64'(rd_busy[1]), 64'(vt[k].b1));
        end

        csr_wen = 1'b1;
        csr_waddr = 2'd0;
        csr_wdata = 64'h8;
        tick();
        idle();
        rd_csr(2'd0, d);
        chk("mstatus_wr", d, 64'h8);

        trap_en = 1'b1;
        trap_epc = 64'h80000010;
        trap_cause = 64'd11;
        csr_wen = 1'b1;
        csr_waddr = 2'd2;
        csr_wdata = 64'h5;
        tick();
        idle();
        rd_csr(2'd2, d);
        chk("trap_mepc", d, 64'h80000010);
        rd_csr(2'd3, d);
        chk("trap_mcause", d, 64'd11);
        rd_csr(2'd0, d);
        chk("trap_mstatus", d, 64'h1880);

        mret_en = 1'b1;
        csr_wen = 1'b1;
        csr_waddr = 2'd1;
        csr_wdata = 64'h100;
        tick();
        idle();
        rd_csr(2'd0, d);
        chk("mret_mstatus", d, 64'h88);
        rd_csr(2'd1, d);
        chk("mret_mtvec_wr", d, 64'h100);

        wr_en = 2'b01;
        wr_addr = {5'd0, 5'd9};
        wr_data = {64'h0, 64'habc};
        rd_addr = {5'd0, 5'd9};
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("bypass_x9", rd_data[63:0], 64'habc);
`else
        chk("bypass_x9", rd_data[63:0], 64'h99);
`endif
        tick();
        idle();
        rd_gpr(5'd9, d, b);
        chk("x9_stored", d, 64'habc);

        wr_en = 2'b01;
        wr_addr = {5'd0, 5'd3};
        wr_data = {64'h0, 64'h33};
        tick();
        idle();
        rd_gpr(5'd3, d, b);
        chk("x3_run", d, 64'h33);

        rst = 1'b1;
        tick();
        rst = 1'b0;
        wr_en = 2'b01;
        wr_addr = {5'd0, 5'd4};
        wr_data = {64'h0, 64'h44};
        sb_set_en = 1'b1;
        sb_set_addr = 5'd4;
        for (int i = 0; i < 9; i++) tick();
        chk("ready_mid_init", 64'(ready), 64'h0);
        rd_addr = {5'd4, 5'd3};
        #1;
        chk("init_rd_zero", rd_data[63:0], 64'h0);
        rst = 1'b1;
        tick();
        chk("ready_after_rst", 64'(ready), 64'h0);
        rst = 1'b0;
        wait_ready(n);
        idle();
        chk("ready_restart", 64'(n), 64'd32);
        rd_gpr(5'd3, d, b);
        chk("x3_cleared", d, 64'h0);
        rd_gpr(5'd4, d, b);
        chk("x4_dropped", d, 64'h0);
        chk("x4_not_busy", 64'(b), 64'h0);
        rd_gpr(5'd5, d, b);
        chk("x5_cleared", d, 64'h0);
        rd_csr(2'd0, d);
        chk("mstatus_rst2", d, 64'ha00001800);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
